// File: rtl/spi_word_slave.sv
`timescale 1ns/1ps
// SPI slave that moves one WIDTH-bit word per transfer slot. It has a
// single-entry TX holding register and a single RX output register. All
// SPI pins are resynchronised into the clk domain.
module spi_word_slave #(
  parameter int WIDTH     = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ssel,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [2:0]       r_sck_sync;
  logic [2:0]       r_ssel_sync;
  logic [1:0]       r_mosi_sync;

  logic [CW-1:0]    r_bit_cnt;
  logic             r_wrapped;
  logic [WIDTH-1:0] r_rx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_rx_overrun;

  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_tx_shift;
  logic             r_tx_underrun;

  logic             w_sck_rise;
  logic             w_sck_fall;
  logic             w_ssel_fall;
  logic             w_lead;
  logic             w_trail;
  logic             w_active;
  logic             w_en;
  logic             w_stop;
  logic             w_start;
  logic             w_sample;
  logic             w_shift;
  logic             w_wrap;
  logic             w_load;
  logic             w_mosi;
  logic             w_tx_wr;
  logic [WIDTH-1:0] w_rx_next;
  logic [WIDTH-1:0] w_tx_shifted;

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_ssel_sync <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], sck};
      r_ssel_sync <= {r_ssel_sync[1:0], ssel};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
    end
  end

  assign w_sck_rise  =  r_sck_sync[1]  & ~r_sck_sync[2];
  assign w_sck_fall  = ~r_sck_sync[1]  &  r_sck_sync[2];
  assign w_ssel_fall = ~r_ssel_sync[1] &  r_ssel_sync[2];
  assign w_mosi      =  r_mosi_sync[1];

  // ---------------------------------------------------------------------
  // Select/transfer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Entry requires a seen falling edge, so a select held low through reset
  // stays ignored until it has been observed high.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_ssel_fall)    w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (r_ssel_sync[1]) w_state_nxt = ST_IDLE;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_active = (r_state == ST_ACTIVE);
    busy     = w_active;
  end

  // ---------------------------------------------------------------------
  // Edge classification
  // ---------------------------------------------------------------------
  always_comb begin
    w_lead   = (CPOL == 0) ? w_sck_rise : w_sck_fall;
    w_trail  = (CPOL == 0) ? w_sck_fall : w_sck_rise;
    w_en     = w_active & ~r_ssel_sync[1];
    w_stop   = w_active &  r_ssel_sync[1];
    w_start  = (r_state == ST_IDLE) & w_ssel_fall;
    w_sample = w_en & ((CPHA == 0) ? w_lead  : w_trail);
    w_shift  = w_en & ((CPHA == 0) ? w_trail : w_lead);
    w_wrap   = w_sample & (r_bit_cnt == LAST);
  end

  assign w_load = (CPHA == 0) ? (w_start | (w_shift & r_wrapped))
                              : (w_shift & (r_bit_cnt == '0));

  // ---------------------------------------------------------------------
  // Bit counter and word-boundary tracking
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !w_en) begin
      r_bit_cnt <= '0;
    end else if (w_sample) begin
      r_bit_cnt <= (r_bit_cnt == LAST) ? '0 : r_bit_cnt + CW'(1);
    end
  end

  // Remembers that the last sample closed a word, so the following shift
  // edge becomes the reload point in CPHA=0 mode.
  always_ff @(posedge clk) begin
    if (rst || !w_en) begin
      r_wrapped <= 1'b0;
    end else if (w_wrap) begin
      r_wrapped <= 1'b1;
    end else if (w_shift) begin
      r_wrapped <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------
  assign w_rx_next = (MSB_FIRST != 0) ? {r_rx_shift[WIDTH-2:0], w_mosi}
                                      : {w_mosi, r_rx_shift[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst || !w_en) begin
      r_rx_shift <= '0;
    end else if (w_sample) begin
      r_rx_shift <= w_rx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_overrun <= 1'b0;
      if (w_wrap) begin
        r_rx_data    <= w_rx_next;
        r_rx_valid   <= 1'b1;
        r_rx_overrun <= r_rx_valid & ~rx_ready;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid   <= 1'b0;
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_overrun = r_rx_overrun;

  // ---------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------
  assign w_tx_wr      = tx_valid & ~r_hold_full;
  assign w_tx_shifted = (MSB_FIRST != 0) ? {r_tx_shift[WIDTH-2:0], 1'b0}
                                         : {1'b0, r_tx_shift[WIDTH-1:1]};

  // A write landing in the same cycle as a load only fills the holding
  // register; the load itself sees it empty and underruns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_tx_shift    <= '0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_underrun <= w_load & ~r_hold_full;
      if (w_tx_wr) begin
        r_hold <= tx_data;
      end
      if (w_load && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_tx_wr) begin
        r_hold_full <= 1'b1;
      end
      if (w_load) begin
        r_tx_shift <= r_hold_full ? r_hold : '0;
      end else if (w_shift) begin
        r_tx_shift <= w_tx_shifted;
      end else if (w_stop) begin
        r_tx_shift <= '0;
      end
    end
  end

  assign tx_ready    = ~r_hold_full;
  assign tx_underrun = r_tx_underrun;

  always_comb begin
    miso = 1'b0;
    if (w_active) begin
      miso = (MSB_FIRST != 0) ? r_tx_shift[WIDTH-1] : r_tx_shift[0];
    end
  end

endmodule

// File: tb/tb_spi_word_slave.sv
`timescale 1ns/1ps
// Bench for spi_word_slave: three instances (mode 0 / 8 bit, mode 3 / 16 bit
// LSB-first, mode 1 / 8 bit) driven by a bit-level SPI master task.
module tb_spi_word_slave;

  localparam int HALF = 8;   // clk cycles per sck half period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sck0, ssel0, mosi0;
  logic sck1, ssel1, mosi1;

  logic [7:0]  a_txd, a_rxd;
  logic        a_txv, a_txr, a_rxv, a_rxr, a_ovr, a_und, a_busy, a_miso;
  logic [15:0] b_txd, b_rxd;
  logic        b_txv, b_txr, b_rxv, b_rxr, b_ovr, b_und, b_busy, b_miso;
  logic [7:0]  c_txd = '0;
  logic [7:0]  c_rxd;
  logic        c_txv = 1'b0;
  logic        c_rxr = 1'b1;
  logic        c_txr, c_rxv, c_ovr, c_und, c_busy, c_miso;

  spi_word_slave #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .sck(sck0), .ssel(ssel0), .mosi(mosi0), .miso(a_miso),
    .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(a_txr),
    .rx_data(a_rxd), .rx_valid(a_rxv), .rx_ready(a_rxr),
    .rx_overrun(a_ovr), .tx_underrun(a_und), .busy(a_busy));

  spi_word_slave #(.WIDTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .sck(sck1), .ssel(ssel1), .mosi(mosi1), .miso(b_miso),
    .tx_data(b_txd), .tx_valid(b_txv), .tx_ready(b_txr),
    .rx_data(b_rxd), .rx_valid(b_rxv), .rx_ready(b_rxr),
    .rx_overrun(b_ovr), .tx_underrun(b_und), .busy(b_busy));

  spi_word_slave #(.WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .sck(sck0), .ssel(ssel0), .mosi(mosi0), .miso(c_miso),
    .tx_data(c_txd), .tx_valid(c_txv), .tx_ready(c_txr),
    .rx_data(c_rxd), .rx_valid(c_rxv), .rx_ready(c_rxr),
    .rx_overrun(c_ovr), .tx_underrun(c_und), .busy(c_busy));

  int total = 0;
  int bad   = 0;

  // Reference-side storage: master bit stream, captured miso bits, TX words.
  logic        mbits[$];
  logic        cap_a[$], cap_b[$], cap_c[$];
  logic [31:0] txw[$];

  // Event monitors (negedge: away from the DUT's active edge).
  int a_ovr_n = 0, a_und_n = 0, b_ovr_n = 0, b_und_n = 0, c_und_n = 0;
  logic [31:0] a_rxq[$], b_rxq[$], c_rxq[$];
  always @(negedge clk) begin
    if (a_ovr) a_ovr_n++;
    if (a_und) a_und_n++;
    if (b_ovr) b_ovr_n++;
    if (b_und) b_und_n++;
    if (c_und) c_und_n++;
    if (a_rxv && a_rxr) a_rxq.push_back(32'(a_rxd));
    if (b_rxv && b_rxr) b_rxq.push_back(32'(b_rxd));
    if (c_rxv && c_rxr) c_rxq.push_back(32'(c_rxd));
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_bit(input int sel, input int idx);
    case (sel)
      0:       return (idx < mbits.size()) ? mbits[idx] : 1'bx;
      1:       return (idx < cap_a.size()) ? cap_a[idx] : 1'bx;
      2:       return (idx < cap_b.size()) ? cap_b[idx] : 1'bx;
      default: return (idx < cap_c.size()) ? cap_c[idx] : 1'bx;
    endcase
  endfunction

  // Word assembled from a bit stream: first bit on the wire is the MSB
  // (msb=1) or the LSB (msb=0).
  function automatic logic [31:0] pack(input int sel, input int start, input int w, input bit msb);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < w; i++) begin
      if (msb) v[w-1-i] = get_bit(sel, start + i);
      else     v[i]     = get_bit(sel, start + i);
    end
    return v;
  endfunction

  function automatic logic [31:0] rx_at(input int sel, input int idx);
    case (sel)
      0:       return (idx < a_rxq.size()) ? a_rxq[idx] : 'x;
      1:       return (idx < b_rxq.size()) ? b_rxq[idx] : 'x;
      default: return (idx < c_rxq.size()) ? c_rxq[idx] : 'x;
    endcase
  endfunction

  task automatic push_word(input logic [31:0] word, input int w, input bit msb);
    for (int i = 0; i < w; i++) mbits.push_back(msb ? word[w-1-i] : word[i]);
  endtask

  task automatic new_xfer();
    mbits.delete(); cap_a.delete(); cap_b.delete(); cap_c.delete(); txw.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".a.miso"},   32'(a_miso), 0);
    check({tag, ".a.txrdy"},  32'(a_txr),  1);
    check({tag, ".a.rxdata"}, 32'(a_rxd),  0);
    check({tag, ".a.rxvld"},  32'(a_rxv),  0);
    check({tag, ".a.ovr"},    32'(a_ovr),  0);
    check({tag, ".a.und"},    32'(a_und),  0);
    check({tag, ".a.busy"},   32'(a_busy), 0);
    check({tag, ".b.flags"},  32'({b_miso, b_txr, b_rxv, b_ovr, b_und, b_busy}), 32'b010000);
    check({tag, ".b.rxdata"}, 32'(b_rxd), 0);
    check({tag, ".c.flags"},  32'({c_miso, c_txr, c_rxv, c_ovr, c_und, c_busy}), 32'b010000);
    check({tag, ".c.rxdata"}, 32'(c_rxd), 0);
  endtask

  task automatic set_sck(input int grp, input logic v);
    if (grp == 0) sck0 = v; else sck1 = v;
  endtask
  task automatic set_ssel(input int grp, input logic v);
    if (grp == 0) ssel0 = v; else ssel1 = v;
  endtask
  task automatic set_mosi(input int grp, input logic v);
    if (grp == 0) mosi0 = v; else mosi1 = v;
  endtask
  task automatic capture(input int grp);
    if (grp == 0) begin cap_a.push_back(a_miso); cap_c.push_back(c_miso); end
    else cap_b.push_back(b_miso);
  endtask

  task automatic tx_write(input int sel, input logic [31:0] d);
    if (sel == 0) begin a_txd = d[7:0]; a_txv = 1'b1; end
    else begin b_txd = d[15:0]; b_txv = 1'b1; end
    wait_clk(1);
    a_txv = 1'b0;
    b_txv = 1'b0;
  endtask

  // Refill the holding register with txw[from..] as soon as it empties.
  task automatic feed(input int sel, input int from);
    for (int k = from; k < txw.size(); k++) begin
      int t;
      t = 0;
      while (!(sel == 0 ? a_txr : b_txr) && t < 4000) begin wait_clk(1); t++; end
      check("feed.ready", 32'(sel == 0 ? a_txr : b_txr), 1);
      if (sel == 0 ? a_txr : b_txr) tx_write(sel, txw[k]);
    end
  endtask

  // Bit-level master: sends mbits in one select window; master samples miso
  // just before each slave sample edge. rst_at>=0 pulses rst before that bit.
  task automatic spi_run(input int grp, input bit cpol, input bit cpha, input int rst_at);
    set_sck(grp, cpol);
    wait_clk(HALF);
    set_ssel(grp, 1'b0);
    wait_clk(2 * HALF);
    for (int i = 0; i < mbits.size(); i++) begin
      if (i == rst_at) begin
        rst = 1'b1; wait_clk(3);
        check_reset("midrst");
        rst = 1'b0; wait_clk(2);
      end
      if (!cpha) begin
        set_mosi(grp, mbits[i]); wait_clk(HALF);
        capture(grp);
        set_sck(grp, !cpol); wait_clk(HALF);
        set_sck(grp, cpol);
      end else begin
        set_sck(grp, !cpol); set_mosi(grp, mbits[i]); wait_clk(HALF);
        capture(grp);
        set_sck(grp, cpol); wait_clk(HALF);
      end
    end
    wait_clk(HALF);
    set_ssel(grp, 1'b1);
    wait_clk(2 * HALF);
  endtask

  initial begin
    int base, u0, o0, cb, cu;
    int n;
    logic [31:0] w1, w2, p1, p2;

    rst = 1'b1;
    sck0 = 1'b0; ssel0 = 1'b1; mosi0 = 1'b0;
    sck1 = 1'b1; ssel1 = 1'b1; mosi1 = 1'b0;
    a_txd = '0; a_txv = 1'b0; a_rxr = 1'b1;
    b_txd = '0; b_txv = 1'b0; b_rxr = 1'b1;
    wait_clk(4);
    check_reset("rst");
    rst = 1'b0;
    wait_clk(4);

    // Mode 0: preload A5, master sends 3C.
    new_xfer();
    base = a_rxq.size(); u0 = a_und_n; o0 = a_ovr_n;
    tx_write(0, 32'hA5);
    check("m0.txready_full", 32'(a_txr), 0);
    push_word(32'h3C, 8, 1);
    spi_run(0, 1'b0, 1'b0, -1);
    check("m0.miso",   pack(1, 0, 8, 1), 32'hA5);
    check("m0.rxcnt",  32'(a_rxq.size() - base), 1);
    check("m0.rxdata", rx_at(0, base), 32'h3C);
    check("m0.und",    32'(a_und_n - u0), 1);   // reload after the last word
    check("m0.ovr",    32'(a_ovr_n - o0), 0);
    check("m0.busy",   32'(a_busy), 0);

    // Mode 3, 16 bit, LSB first, two-word burst.
    new_xfer();
    base = b_rxq.size(); u0 = b_und_n; o0 = b_ovr_n;
    txw.push_back(32'h1234); txw.push_back(32'hBEEF);
    push_word(32'h00FF, 16, 0); push_word(32'h8001, 16, 0);
    tx_write(1, txw[0]);
    fork
      spi_run(1, 1'b1, 1'b1, -1);
      feed(1, 1);
    join
    check("m3.miso0", pack(2, 0, 16, 0), 32'h1234);
    check("m3.miso1", pack(2, 16, 16, 0), 32'hBEEF);
    check("m3.rx0",   rx_at(1, base), 32'h00FF);
    check("m3.rx1",   rx_at(1, base + 1), 32'h8001);
    check("m3.ovr",   32'(b_ovr_n - o0), 0);
    check("m3.und",   32'(b_und_n - u0), 0);

    // Mode 1 with no preload: one underrun, miso all zero.
    new_xfer();
    cb = c_rxq.size(); cu = c_und_n;
    w1 = $urandom & 32'hFF;
    push_word(w1, 8, 1);
    spi_run(0, 1'b0, 1'b1, -1);
    check("m1.miso", pack(3, 0, 8, 1), 0);
    check("m1.und",  32'(c_und_n - cu), 1);
    check("m1.rx",   rx_at(2, cb), w1);

    // Overrun: rx_ready low across two words.
    new_xfer();
    base = a_rxq.size(); o0 = a_ovr_n; u0 = a_und_n;
    a_rxr = 1'b0;
    w1 = $urandom & 32'hFF; w2 = $urandom & 32'hFF;
    push_word(w1, 8, 1); push_word(w2, 8, 1);
    spi_run(0, 1'b0, 1'b0, -1);
    check("ovr.count",  32'(a_ovr_n - o0), 1);
    check("ovr.rxdata", 32'(a_rxd), w2);
    check("ovr.rxvld",  32'(a_rxv), 1);
    check("ovr.und",    32'(a_und_n - u0), 3);
    check("ovr.miso",   pack(1, 0, 16, 1), 0);
    a_rxr = 1'b1;
    wait_clk(1);
    check("ovr.rxvld_clr", 32'(a_rxv), 0);
    wait_clk(2);

    // Partial word (5 bits) then a full word 0x81.
    new_xfer();
    base = a_rxq.size(); u0 = a_und_n;
    p1 = $urandom & 32'hFF;
    tx_write(0, p1);
    for (int i = 0; i < 5; i++) mbits.push_back(1'($urandom & 1));
    spi_run(0, 1'b0, 1'b0, -1);
    check("part.rxcnt", 32'(a_rxq.size() - base), 0);
    check("part.miso",  pack(1, 0, 5, 1), p1 >> 3);
    check("part.und",   32'(a_und_n - u0), 0);
    check("part.txrdy", 32'(a_txr), 1);
    check("part.busy",  32'(a_busy), 0);
    new_xfer();
    p2 = $urandom & 32'hFF;
    tx_write(0, p2);
    push_word(32'h81, 8, 1);
    spi_run(0, 1'b0, 1'b0, -1);
    check("part.rxcnt2", 32'(a_rxq.size() - base), 1);
    check("part.rx",     rx_at(0, base), 32'h81);
    check("part.rxdata", 32'(a_rxd), 32'h81);
    check("part.miso2",  pack(1, 0, 8, 1), p2);

    // Reset after bit 3, then a clean transfer.
    new_xfer();
    base = a_rxq.size();
    tx_write(0, $urandom & 32'hFF);
    push_word($urandom & 32'hFF, 8, 1);
    spi_run(0, 1'b0, 1'b0, 3);
    check("mrst.rxcnt", 32'(a_rxq.size() - base), 0);
    check("mrst.miso",  pack(1, 3, 5, 1), 0);
    check("mrst.busy",  32'(a_busy), 0);
    check("mrst.txrdy", 32'(a_txr), 1);
    new_xfer();
    u0 = a_und_n; o0 = a_ovr_n;
    p1 = $urandom & 32'hFF; w1 = $urandom & 32'hFF;
    tx_write(0, p1);
    push_word(w1, 8, 1);
    spi_run(0, 1'b0, 1'b0, -1);
    check("mrst.miso2", pack(1, 0, 8, 1), p1);
    check("mrst.rx",    rx_at(0, base), w1);
    check("mrst.und",   32'(a_und_n - u0), 1);
    check("mrst.ovr",   32'(a_ovr_n - o0), 0);

    // Randomised bursts on both bus groups.
    for (int it = 0; it < 4; it++) begin
      new_xfer();
      n = int'($urandom_range(3, 1));
      base = a_rxq.size(); u0 = a_und_n; o0 = a_ovr_n;
      for (int k = 0; k < n; k++) begin
        txw.push_back($urandom & 32'hFF);
        push_word($urandom & 32'hFF, 8, 1);
      end
      tx_write(0, txw[0]);
      fork
        spi_run(0, 1'b0, 1'b0, -1);
        feed(0, 1);
      join
      for (int k = 0; k < n; k++) begin
        check($sformatf("rndA.miso%0d", k), pack(1, 8 * k, 8, 1), txw[k]);
        check($sformatf("rndA.rx%0d", k), rx_at(0, base + k), pack(0, 8 * k, 8, 1));
      end
      check("rndA.und", 32'(a_und_n - u0), 1);
      check("rndA.ovr", 32'(a_ovr_n - o0), 0);

      new_xfer();
      n = int'($urandom_range(3, 1));
      base = b_rxq.size(); u0 = b_und_n; o0 = b_ovr_n;
      for (int k = 0; k < n; k++) begin
        txw.push_back($urandom & 32'hFFFF);
        push_word($urandom & 32'hFFFF, 16, 0);
      end
      tx_write(1, txw[0]);
      fork
        spi_run(1, 1'b1, 1'b1, -1);
        feed(1, 1);
      join
      for (int k = 0; k < n; k++) begin
        check($sformatf("rndB.miso%0d", k), pack(2, 16 * k, 16, 0), txw[k]);
        check($sformatf("rndB.rx%0d", k), rx_at(1, base + k), pack(0, 16 * k, 16, 0));
      end
      check("rndB.und", 32'(b_und_n - u0), 0);
      check("rndB.ovr", 32'(b_ovr_n - o0), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_word_slave.md
SPI_WORD_SLAVE -- requirements
Module: spi_word_slave

Interface
REQ-001 Parameter WIDTH, default 8: bits per SPI word; legal range 2..32.
REQ-002 Parameter CPOL, default 0: SCK idle level.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1: 1 = MSB shifted first, 0 = LSB first.
REQ-005 clk  input  1  system clock; the block SHALL use one clock only, and every flop SHALL be clocked on its rising edge.
REQ-006 rst  input  1  reset; it SHALL be synchronous and active-high.
REQ-007 sck  input  1  SPI clock, asynchronous to clk.
REQ-008 ssel  input  1  slave select, active low, asynchronous.
REQ-009 mosi  input  1  master-out data, asynchronous.
REQ-010 miso  output  1  slave-out data.
REQ-011 tx_data  input  WIDTH  next word to transmit.
REQ-012 tx_valid  input  1  tx_data is valid.
REQ-013 tx_ready  output  1  the TX holding register is empty.
REQ-014 rx_data  output  WIDTH  last received word.
REQ-015 rx_valid  output  1  rx_data is unread.
REQ-016 rx_ready  input  1  consumer accepts rx_data.
REQ-017 rx_overrun  output  1  one-clk pulse: an unread word was overwritten.
REQ-018 tx_underrun  output  1  one-clk pulse: a word load found the holding register empty.
REQ-019 busy  output  1  synchronized ssel is active.

Function
REQ-020 sck and ssel SHALL pass through 3-flop synchronizers; edges SHALL be detected on stages [2:1]; mosi SHALL pass through 2 flops.
REQ-021 The leading edge SHALL be the rising edge when CPOL=0 and the falling edge when CPOL=1; the sample edge SHALL be the leading edge when CPHA=0, else the trailing edge; the shift edge SHALL be the other edge.
REQ-022 A bit counter (width clog2(WIDTH)) SHALL count sample edges while busy, wrap from WIDTH-1 to 0, and clear whenever busy=0.
REQ-023 On each sample edge, mosi SHALL shift into the RX shift register in MSB_FIRST order.
REQ-024 On the sample edge that wraps the counter, the cycle after the edge-detect cycle SHALL have rx_data = the full word and rx_valid = 1.
REQ-025 rx_valid SHALL clear on the cycle after rx_valid&&rx_ready, unless a new word completes in that same cycle, in which case it SHALL stay 1 with the new data and no overrun.
REQ-026 If a word completes while rx_valid=1 and rx_ready=0, rx_data SHALL be overwritten and rx_overrun SHALL pulse for 1 clk.
REQ-027 tx_ready SHALL equal NOT holding_full; tx_valid&&tx_ready SHALL capture tx_data, and holding_full SHALL be set on the next clk.
REQ-028 Load event for CPHA=0: the ssel falling (start) edge, plus the shift edge that immediately follows a counter wrap.
REQ-029 Load event for CPHA=1: any shift edge with bit counter = 0.
REQ-030 At a load event with holding_full=1, the TX shift register SHALL take the holding register and holding_full SHALL clear.
REQ-031 At a load event with holding_full=0, the TX shift register SHALL load all zeros and tx_underrun SHALL pulse.
REQ-032 A tx_valid write in the same cycle as a load event SHALL NOT bypass into the shift register; that load SHALL count as an underrun, and the write SHALL land in the holding register.
REQ-033 On non-load shift edges, the TX shift register SHALL shift by one bit toward the output end.
REQ-034 miso SHALL be the output-end bit of the TX shift register while busy, and 0 while idle.
REQ-035 When ssel deasserts mid-word, the partial RX word SHALL be discarded with no rx_valid, the TX shift register SHALL be cleared, and the holding register and rx_data SHALL be kept.
REQ-036 Consecutive words within one ssel assertion SHALL be supported with no gap cycles.
REQ-037 sck edges while busy=0 SHALL be ignored.

Reset
REQ-038 While rst=1, the outputs SHALL be: miso=0, tx_ready=1, rx_data=0, rx_valid=0, rx_overrun=0, tx_underrun=0, busy=0.
REQ-039 While rst=1, all synchronizers, counters, shift registers and the holding register SHALL clear.
REQ-040 rst asserted mid-transfer SHALL abort the transfer; the block SHALL resume only at the next ssel falling edge after rst=0 and ssel is seen high.

Verification
REQ-041 Mode 0, WIDTH=8: preload 0xA5, master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid=1.
REQ-042 Mode 3, WIDTH=16, MSB_FIRST=0: 2-word burst, TX 0x1234 then 0xBEEF, RX 0x00FF then 0x8001 -> both words correct, rx_ready held 1, no overrun or underrun.
REQ-043 No preload, mode 1: one word -> tx_underrun pulses once; miso is all 0.
REQ-044 rx_ready held 0 across two words -> rx_overrun pulses once; rx_data = the second word.
REQ-045 ssel released after 5 bits, then a full word 0x81 -> no rx_valid for the partial word; rx_data=0x81.
REQ-046 rst pulsed after bit 3 -> all outputs at reset values; the next full transfer is correct.
